// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: round-robin arbiter sharing one single-ported data RAM
// between the CPU MEM stage (master 0) and the refill/writeback engine
// (master 1). Each access takes one SERVE cycle on the RAM pins, followed by
// a registered ack/rdata pulse to the granted master.
module data_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_stall,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;   // master served most recently; the other wins a tie
  logic       elig0;
  logic       elig1;

  // A master whose ack is high this cycle has either dropped req or just
  // presented a new request; the new one competes from the next IDLE cycle.
  assign elig0 = m0_req & ~m0_ack;
  assign elig1 = m1_req & ~m1_ack;

  assign m0_stall = m0_req & ~m0_ack;

  // Next-state selection: arbitrate in IDLE, always return to IDLE after SERVE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if can leave it unassigned and infer a latch.
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (elig0 && elig1) state_nxt = last ? SERVE0 : SERVE1;
        else if (elig0)     state_nxt = SERVE0;
        else if (elig1)     state_nxt = SERVE1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin pointer; reset lets master 0 win first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == SERVE0)      last <= 1'b0;
      else if (state == SERVE1) last <= 1'b1;
    end
  end

  // Registered completion: ack pulses one cycle after SERVE; reads capture
  // RAM data, writes leave the previous rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are ordinary output registers, not storage arrays, so
      // resetting them is cheap and gives the pipeline a defined rdata.
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= (state == SERVE0);
      m1_ack <= (state == SERVE1);
      if (state == SERVE0 && !m0_we) m0_rdata <= ram_rdata;
      if (state == SERVE1 && !m1_we) m1_rdata <= ram_rdata;
    end
  end

  // RAM pin mux: driven from the granted master during SERVE, all zero
  // otherwise. Purely a function of state, so a reset asserted during SERVE
  // still lets that cycle's access reach the RAM.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      SERVE0: begin
        ram_ce    = 1'b1;
        ram_we    = m0_we;
        ram_sel   = m0_sel;
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
      end
      SERVE1: begin
        ram_ce    = 1'b1;
        ram_we    = m1_we;
        ram_sel   = m1_sel;
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: scoreboard bench. Expected rdata is computed from a
// shadow memory when each request is issued and queued per master; a monitor
// pops and compares on every ack and checks the handshake invariants.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack, m0_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Data RAM attached to the DUT: combinational read, byte-enabled write.
  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];   // reference copy, updated at issue time
  assign ram_rdata = mem[ram_addr[11:2]];
  always @(posedge clk)
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    int          start;   // first cycle the request is eligible for grant
  } exp_t;

  exp_t        q0[$], q1[$];
  int          ack_id[$], ack_cyc[$];
  logic [31:0] last_rd0 = '0, last_rd1 = '0;
  int          vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on every ack.
  logic p0 = 1'b0, p1 = 1'b0;
  exp_t e0, e1;
  always @(negedge clk) begin
    check("stall", m0_stall, m0_req & ~m0_ack);
    check("ack_overlap", m0_ack & m1_ack, 0);
    check("ack0_pulse", p0 & m0_ack, 0);
    check("ack1_pulse", p1 & m1_ack, 0);
    if (ram_ce !== 1'b1) begin
      check("ram_idle_ctl", {ram_we, ram_sel}, 0);
      check("ram_idle_addr", ram_addr, 0);
      check("ram_idle_wdata", ram_wdata, 0);
    end
    if (m0_ack === 1'b1) begin
      if (q0.size() == 0) check("ack0_unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("m0_rdata", m0_rdata, e0.rdata);
        check("m0_latency_2to4", (cyc - e0.start >= 2) && (cyc - e0.start <= 4), 1);
        ack_id.push_back(0);
        ack_cyc.push_back(cyc);
      end
    end
    if (m1_ack === 1'b1) begin
      if (q1.size() == 0) check("ack1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("m1_rdata", m1_rdata, e1.rdata);
        check("m1_latency_2to4", (cyc - e1.start >= 2) && (cyc - e1.start <= 4), 1);
        ack_id.push_back(1);
        ack_cyc.push_back(cyc);
      end
    end
    p0 <= m0_ack;
    p1 <= m1_ack;
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // Present a request and queue its expected response. in_ack: issued during
  // this master's ack cycle, so it only becomes eligible one cycle later.
  task automatic issue(input int m, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, input bit in_ack);
    exp_t        e;
    logic [31:0] word;
    word = shadow[a[11:2]];
    if (!w) begin
      e.rdata = word;
      if (m == 0) last_rd0 = word; else last_rd1 = word;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
      shadow[a[11:2]] = word;
      e.rdata = (m == 0) ? last_rd0 : last_rd1;
    end
    e.start = cyc + (in_ack ? 1 : 0);
    if (m == 0) begin
      q0.push_back(e);
      m0_we = w; m0_sel = s; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
    end else begin
      q1.push_back(e);
      m1_we = w; m1_sel = s; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  // Wait (bounded) for master m's ack; returns just after the sampling edge.
  task automatic wait_ack(input int m, output int ack_at);
    ack_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (((m == 0) ? m0_ack : m1_ack) === 1'b1) begin
        ack_at = cyc;
        break;
      end
    end
    if (ack_at < 0) check(m == 0 ? "ack0_timeout" : "ack1_timeout", 0, 1);
    #1;
  endtask

  task automatic restart_pending(input int r);
    foreach (q0[i]) q0[i].start = r;
    foreach (q1[i]) q1[i].start = r;
  endtask

  task automatic run_master(input int m, input int n);
    int          at, gap;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      gap = (i == 0) ? 1 : int'($urandom_range(0, 3));
      a   = ((m == 0) ? 32'h0 : 32'h200) + ($urandom_range(0, 63) << 2);
      if (gap > 0) begin
        drop(m);
        repeat (gap) sync();
        issue(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 1'b0);
      end else begin
        issue(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 1'b1);
      end
      wait_ack(m, at);
    end
    drop(m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r, at, at2, base;
    logic [31:0] old;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    mem[32'h100 >> 2]    = 32'hDEADBEEF;
    shadow[32'h100 >> 2] = 32'hDEADBEEF;

    // Reset with both masters requesting; master 0 must win the first tie.
    sync();
    issue(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
    issue(1, 1'b0, 4'hF, 32'h004, 32'h0, 1'b0);
    sync();
    sync();
    check("rst_acks", {m0_ack, m1_ack}, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    rst = 1'b0;
    r = cyc;
    restart_pending(r);
    wait_ack(0, at);
    check("rst_m0_first_at_r2", at - r, 2);
    drop(0);
    wait_ack(1, at);
    drop(1);

    // Single uncontested read: cycle-exact RAM pins, ack and stall.
    sync();
    issue(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
    #1;
    check("rd_stall_n", m0_stall, 1);
    @(negedge clk);
    check("rd_ram_ce", ram_ce, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_addr, 32'h100);
    check("rd_stall_n1", m0_stall, 1);
    @(negedge clk);
    check("rd_ack", m0_ack, 1);
    check("rd_data", m0_rdata, 32'hDEADBEEF);
    check("rd_stall_n2", m0_stall, 0);
    #1;
    drop(0);

    // Byte-lane write by master 1, then read back by master 0.
    sync();
    old = shadow[32'h204 >> 2];
    issue(1, 1'b1, 4'b0010, 32'h204, 32'h0000AB00, 1'b0);
    @(negedge clk);
    check("bw_ram_we", ram_we, 1);
    check("bw_ram_sel", ram_sel, 4'b0010);
    check("bw_ram_wdata", ram_wdata, 32'h0000AB00);
    wait_ack(1, at);
    drop(1);
    sync();
    issue(0, 1'b0, 4'hF, 32'h204, 32'h0, 1'b0);
    wait_ack(0, at);
    check("bw_readback", m0_rdata, (old & 32'hFFFF00FF) | 32'h0000AB00);
    drop(0);

    // Contention: both masters re-request in every ack cycle for 8 accesses.
    sync();
    base = ack_id.size();
    issue(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    issue(1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
    fork
      begin
        int a0;
        for (int k = 0; k < 4; k++) begin
          wait_ack(0, a0);
          if (k < 3) issue(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1); else drop(0);
        end
      end
      begin
        int a1;
        for (int k = 0; k < 4; k++) begin
          wait_ack(1, a1);
          if (k < 3) issue(1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b1); else drop(1);
        end
      end
    join
    check("cont_count", ack_id.size() - base, 8);
    for (int i = base + 1; i < ack_id.size(); i++) begin
      check("cont_alternate", ack_id[i], 1 - ack_id[i-1]);
      check("cont_gap", ack_cyc[i] - ack_cyc[i-1], 2);
    end

    // Back-to-back master 0: the new request is masked in its ack cycle,
    // arbitrated in the next IDLE cycle, served, then acked.
    sync();
    issue(0, 1'b0, 4'hF, 32'h010, 32'h0, 1'b0);
    wait_ack(0, at);
    issue(0, 1'b0, 4'hF, 32'h014, 32'h0, 1'b1);
    wait_ack(0, at2);
    check("b2b_spacing", at2 - at, 3);
    drop(0);

    // Reset during SERVE1: no ack afterwards, re-served after release.
    sync();
    issue(1, 1'b0, 4'hF, 32'h208, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_ce === 1'b1 && ram_addr == 32'h208) break;
    end
    check("mid_serve_seen", {ram_ce, ram_addr}, {1'b1, 32'h208});
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_no_ack", m1_ack, 0);
    check("mid_idle", ram_ce, 0);
    #1;
    rst = 1'b0;
    last_rd0 = '0;
    last_rd1 = '0;
    r = cyc;
    restart_pending(r);
    wait_ack(1, at);
    check("mid_reserve_within4", (at - r) <= 4, 1);
    drop(1);

    // Randomized traffic from both masters in disjoint address regions.
    sync();
    fork
      run_master(0, 30);
      run_master(1, 30);
    join
    repeat (4) sync();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
